mac_layer_sequencer: RTL
========================

// Module: mac_layer_sequencer
// PURPOSE
//  Sequences the 8-lane MAC array through one fully-connected layer: out[n] = sat8(relu?((sum_k act[k]*w[n][k] + bias[n]) >>> shift)).
//  Drives activation/weight/bias memory reads and MAC enable/clear, and accumulates MAC partial sums.
//  Emits one INT8 result per neuron over a valid/ready stream. Shared by the MLP, CNN (im2col) and RNN wrappers.
// PARAMETERS
//  ADDR_W      10   width of activation, weight and bias read addresses
//  CNT_W       10   width of chunk and neuron counters / config fields
//  ACC_W       32   signed accumulator width
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous active-high reset
//  start           in   1       1-cycle pulse; starts layer, sampled only in IDLE
//  cfg_in_chunks   in   CNT_W   input length in 8-element chunks (K/8)
//  cfg_num_out     in   CNT_W   neurons in layer
//  cfg_shift       in   5       requant arithmetic right shift
//  cfg_relu        in   1       1 = clamp negatives to 0
//  busy            out  1       high from accepted start until done
//  done            out  1       1-cycle pulse, layer complete
//  act_rd_en       out  1       activation memory read (1-cycle read latency)
//  act_rd_addr     out  ADDR_W  chunk index
//  wgt_rd_en       out  1       weight memory read (1-cycle latency)
//  wgt_rd_addr     out  ADDR_W  n*cfg_in_chunks + chunk
//  bias_rd_en      out  1       bias memory read (1-cycle latency)
//  bias_rd_addr    out  ADDR_W  neuron index
//  bias_rd_data    in   ACC_W   signed bias
//  mac_enable      out  1       to MAC array enable
//  mac_clear_acc   out  1       to MAC array clear_acc
//  mac_partial_sum in   16      signed MAC array partial_sum
//  mac_valid       in   1       MAC array valid
//  out_valid       out  1       result valid
//  out_ready       in   1       downstream ready
//  out_data        out  8       signed INT8 result
//  out_idx         out  CNT_W   neuron index of out_data
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. On rst: state IDLE; all outputs 0; counters and acc 0.
//  - Config is latched on the accepted start; later changes are ignored until the next start.
//  - start while busy: ignored. start with cfg_in_chunks==0 or cfg_num_out==0: busy for 1 cycle, done next cycle, no reads and no MAC activity.
//  - FSM: IDLE -> CLEAR -> ISSUE -> DRAIN -> BIAS -> EMIT -> (CLEAR for next neuron | DONE) ; DONE -> IDLE.
//    CLEAR   : mac_clear_acc=1 for 1 cycle; acc<=0; chunk<=0.
//    ISSUE   : act_rd_en=wgt_rd_en=1 every cycle, chunk 0..cfg_in_chunks-1 back-to-back. mac_enable is rd_en delayed 1 cycle, aligned with memory data.
//              wgt_rd_addr is a running pointer incremented per read, not a multiply; it continues across neurons.
//    DRAIN   : wait until received mac_valid count == cfg_in_chunks. Assert bias_rd_en (addr=n) on DRAIN entry.
//    BIAS    : acc + bias_rd_data -> requant; result registered into out_data/out_idx.
//    EMIT    : out_valid=1, held with stable data until out_ready; transfer on out_valid&&out_ready.
//              Then n++; the next state is DONE if n==cfg_num_out, else CLEAR.
//    DONE    : done=1 for 1 cycle, busy drops in the same cycle.
//  - Accumulation: on every mac_valid in ISSUE/DRAIN, acc <= acc + sext(mac_partial_sum). Completion is counted, never timed.
//    MAC latency is 4 cycles enable->valid, but the controller must work for any fixed latency.
//  - mac_valid in IDLE/CLEAR/BIAS/EMIT/DONE: ignored. Stale results after a reset mid-layer must not corrupt the next layer.
//  - Requant: t = (acc+bias) >>> cfg_shift (floor); if cfg_relu && t<0 then t=0; saturate to [-128,127]. Accumulation wraps at ACC_W, with no overflow flag.
//  - Neurons do not overlap: no ISSUE for n+1 until neuron n has left EMIT.
//  - Reset mid-layer: back to IDLE in 1 cycle, with no done pulse and out_valid dropped.
//  - Throughput per neuron: cfg_in_chunks + MAC latency + 4 cycles, plus any EMIT stall.
// STRUCTURE
//  - mac_pkg: MAC_LANES=8, MAC_LATENCY=4, ACC_W, seq_state_t enum, function sat_int8(), localparams for the state encoding.
//  - Sub-module mac_requant: combinational add bias, shift, relu, saturate; unit-testable alone.
//  - Counters chunk_cnt, rx_cnt, neuron_cnt and wgt_ptr live in the sequencer; no internal memories.
// TESTING (bench models 1-cycle memories and the 4-stage MAC array)
//  1. K=8 (1 chunk), N=1, act all 1, w all 2, bias 0, shift 0 -> out_data=16, out_idx=0. Then done pulses once; mac_enable high exactly 1 cycle.
//  2. K=32 (4 chunks), N=3, random INT8, bias random, shift 4, relu 0 -> 3 outputs match the golden model bit-exact.
//     wgt_rd_addr sequence 0..11 contiguous.
//  3. Saturation/relu: acc+bias=+5000, shift 2 -> 127; acc+bias=-5000, relu 0 -> -128; relu 1 -> 0.
//  4. Backpressure: out_ready low 10 cycles in EMIT -> out_valid and out_data stable, no new ISSUE until handshake, no outputs lost.
//  5. Edge/abuse: cfg_num_out=0 -> done 1 cycle after start with no reads. start pulsed while busy -> ignored.
//     Config changed mid-layer -> results unchanged.
//  6. rst asserted mid-ISSUE with 3 MAC results in flight -> IDLE next cycle, outputs 0.
//     A new layer run afterwards produces correct results despite the stale mac_valid pulses.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types, widths and helpers for the MAC layer sequencer.
//   MAC_LANES / MAC_LATENCY : MAC array geometry (nominal latency; the controller counts, never times)
//   ADDR_W / CNT_W / ACC_W  : read-address, counter and accumulator widths
//   seq_state_t             : sequencer FSM states
//   sat_int8()              : clamp a signed accumulator-width value to INT8
package mac_pkg;

  localparam int unsigned MAC_LANES   = 8;
  localparam int unsigned MAC_LATENCY = 4;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned PSUM_W      = 16;
  localparam int unsigned SHIFT_W     = 5;
  localparam int unsigned OUT_W       = 8;
  localparam int unsigned STATE_W     = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] ST_BIAS  = 3'd4;
  localparam logic [STATE_W-1:0] ST_EMIT  = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_BIAS  = ST_BIAS,
    S_EMIT  = ST_EMIT,
    S_DONE  = ST_DONE
  } seq_state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  // Saturate to [-128, 127].
  function automatic logic signed [OUT_W-1:0] sat_int8(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return 8'sd127;
    else if (v < SAT_MIN) return -8'sd128;
    else                  return $signed(v[OUT_W-1:0]);
  endfunction

endpackage

// File: rtl/mac_layer_sequencer_if.sv
// Bus bundle between the layer sequencer and its environment
// (config/start, memory read ports, MAC array, result stream).
//   modport seq : sequencer side
//   modport env : memories / MAC array / downstream side
interface mac_layer_sequencer_if;
  import mac_pkg::*;

  logic                      start;
  logic [CNT_W-1:0]          cfg_in_chunks;
  logic [CNT_W-1:0]          cfg_num_out;
  logic [SHIFT_W-1:0]        cfg_shift;
  logic                      cfg_relu;
  logic                      busy;
  logic                      done;
  logic                      act_rd_en;
  logic [ADDR_W-1:0]         act_rd_addr;
  logic                      wgt_rd_en;
  logic [ADDR_W-1:0]         wgt_rd_addr;
  logic                      bias_rd_en;
  logic [ADDR_W-1:0]         bias_rd_addr;
  logic signed [ACC_W-1:0]   bias_rd_data;
  logic                      mac_enable;
  logic                      mac_clear_acc;
  logic signed [PSUM_W-1:0]  mac_partial_sum;
  logic                      mac_valid;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic [CNT_W-1:0]          out_idx;

  modport seq (
    input  start, cfg_in_chunks, cfg_num_out, cfg_shift, cfg_relu,
           bias_rd_data, mac_partial_sum, mac_valid, out_ready,
    output busy, done, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr,
           bias_rd_en, bias_rd_addr, mac_enable, mac_clear_acc,
           out_valid, out_data, out_idx
  );

  modport env (
    output start, cfg_in_chunks, cfg_num_out, cfg_shift, cfg_relu,
           bias_rd_data, mac_partial_sum, mac_valid, out_ready,
    input  busy, done, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr,
           bias_rd_en, bias_rd_addr, mac_enable, mac_clear_acc,
           out_valid, out_data, out_idx
  );

endinterface

// File: rtl/mac_requant.sv
// Combinational requantisation: (acc + bias) >>> shift, optional relu, INT8 saturate.
//   acc_i, bias_i : signed accumulator and bias (sum wraps at ACC_W)
//   shift_i       : arithmetic right shift (floor)
//   relu_i        : clamp negatives to 0
//   res_c_o       : INT8 result (combinational)
module mac_requant
  import mac_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic signed [ACC_W-1:0]   bias_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  input  logic                      relu_i,
  output logic signed [OUT_W-1:0]   res_c_o
);

  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;

  always_comb begin
    sum_c = acc_i + bias_i;
    shr_c = sum_c >>> shift_i;
    if (relu_i && shr_c[ACC_W-1]) shr_c = '0;
    res_c_o = sat_int8(shr_c);
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Sequences the 8-lane MAC array through one fully-connected layer and
// streams one INT8 result per neuron.
//   clk, rst : clock, synchronous active-high reset
//   bus      : config/start, act/wgt/bias reads, MAC control, result stream
module mac_layer_sequencer
  import mac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mac_layer_sequencer_if.seq    bus
);

  seq_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cfg_chunks_q, cfg_chunks_d, cfg_nout_q, cfg_nout_d;
  logic [SHIFT_W-1:0]      cfg_shift_q, cfg_shift_d;
  logic                    cfg_relu_q, cfg_relu_d;
  logic [CNT_W-1:0]        chunk_q, chunk_d, rx_q, rx_d, en_q, en_d, neuron_q, neuron_d;
  logic [ADDR_W-1:0]       wgt_ptr_q, wgt_ptr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, bias_q, bias_d;
  logic                    bias_pend_q, bias_pend_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    act_en_q, act_en_d, wgt_en_q, wgt_en_d, bias_en_q, bias_en_d;
  logic [ADDR_W-1:0]       act_addr_q, act_addr_d, wgt_addr_q, wgt_addr_d, bias_addr_q, bias_addr_d;
  logic                    mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_idx_q, out_idx_d;
  logic signed [OUT_W-1:0] res_c;
  logic                    acc_take_c;

  mac_requant u_requant (
    .acc_i   (acc_q),
    .bias_i  (bias_q),
    .shift_i (cfg_shift_q),
    .relu_i  (cfg_relu_q),
    .res_c_o (res_c)
  );

  // Only accept results for enables issued in this neuron; stale pulses left
  // in the MAC pipe by a reset arrive before any new enable has been counted.
  assign acc_take_c = (state_q == S_ISSUE || state_q == S_DRAIN) &&
                      bus.mac_valid && (rx_q < en_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cfg_chunks_d = cfg_chunks_q;
    cfg_nout_d   = cfg_nout_q;
    cfg_shift_d  = cfg_shift_q;
    cfg_relu_d   = cfg_relu_q;
    chunk_d      = chunk_q;
    rx_d         = rx_q;
    en_d         = mac_en_q ? en_q + CNT_W'(1) : en_q;
    neuron_d     = neuron_q;
    wgt_ptr_d    = wgt_ptr_q;
    acc_d        = acc_q;
    bias_pend_d  = bias_en_q;
    bias_d       = bias_pend_q ? bus.bias_rd_data : bias_q;
    act_en_d     = 1'b0;
    act_addr_d   = act_addr_q;
    wgt_en_d     = 1'b0;
    wgt_addr_d   = wgt_addr_q;
    bias_en_d    = 1'b0;
    bias_addr_d  = bias_addr_q;
    mac_en_d     = act_en_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;

    if (acc_take_c) begin
      acc_d = acc_q + {{(ACC_W-PSUM_W){bus.mac_partial_sum[PSUM_W-1]}}, bus.mac_partial_sum};
      rx_d  = rx_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cfg_chunks_d = bus.cfg_in_chunks;
          cfg_nout_d   = bus.cfg_num_out;
          cfg_shift_d  = bus.cfg_shift;
          cfg_relu_d   = bus.cfg_relu;
          wgt_ptr_d    = '0;
          neuron_d     = '0;
          state_d      = (bus.cfg_in_chunks == '0 || bus.cfg_num_out == '0) ? S_DONE : S_CLEAR;
        end
      end
      // Reset per-neuron counters and launch the first read pair.
      S_CLEAR: begin
        acc_d      = '0;
        rx_d       = '0;
        en_d       = '0;
        act_en_d   = 1'b1;
        act_addr_d = '0;
        wgt_en_d   = 1'b1;
        wgt_addr_d = wgt_ptr_q;
        wgt_ptr_d  = wgt_ptr_q + ADDR_W'(1);
        chunk_d    = CNT_W'(1);
        state_d    = S_ISSUE;
      end
      // chunk_q counts reads already issued for this neuron.
      S_ISSUE: begin
        if (chunk_q == cfg_chunks_q) begin
          bias_en_d   = 1'b1;
          bias_addr_d = ADDR_W'(neuron_q);
          state_d     = S_DRAIN;
        end else begin
          act_en_d   = 1'b1;
          act_addr_d = ADDR_W'(chunk_q);
          wgt_en_d   = 1'b1;
          wgt_addr_d = wgt_ptr_q;
          wgt_ptr_d  = wgt_ptr_q + ADDR_W'(1);
          chunk_d    = chunk_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (rx_q == cfg_chunks_q) state_d = S_BIAS;
      end
      S_BIAS: begin
        out_data_d  = res_c;
        out_idx_d   = neuron_q;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          neuron_d    = neuron_q + CNT_W'(1);
          state_d     = (neuron_q + CNT_W'(1) == cfg_nout_q) ? S_DONE : S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_DONE);
    mac_clr_d = (state_d == S_CLEAR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cfg_chunks_q <= '0;
      cfg_nout_q   <= '0;
      cfg_shift_q  <= '0;
      cfg_relu_q   <= 1'b0;
      chunk_q      <= '0;
      rx_q         <= '0;
      en_q         <= '0;
      neuron_q     <= '0;
      wgt_ptr_q    <= '0;
      acc_q        <= '0;
      bias_q       <= '0;
      bias_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_en_q     <= 1'b0;
      act_addr_q   <= '0;
      wgt_en_q     <= 1'b0;
      wgt_addr_q   <= '0;
      bias_en_q    <= 1'b0;
      bias_addr_q  <= '0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      cfg_chunks_q <= cfg_chunks_d;
      cfg_nout_q   <= cfg_nout_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_relu_q   <= cfg_relu_d;
      chunk_q      <= chunk_d;
      rx_q         <= rx_d;
      en_q         <= en_d;
      neuron_q     <= neuron_d;
      wgt_ptr_q    <= wgt_ptr_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      bias_pend_q  <= bias_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      act_en_q     <= act_en_d;
      act_addr_q   <= act_addr_d;
      wgt_en_q     <= wgt_en_d;
      wgt_addr_q   <= wgt_addr_d;
      bias_en_q    <= bias_en_d;
      bias_addr_q  <= bias_addr_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.act_rd_en     = act_en_q;
  assign bus.act_rd_addr   = act_addr_q;
  assign bus.wgt_rd_en     = wgt_en_q;
  assign bus.wgt_rd_addr   = wgt_addr_q;
  assign bus.bias_rd_en    = bias_en_q;
  assign bus.bias_rd_addr  = bias_addr_q;
  assign bus.mac_enable    = mac_en_q;
  assign bus.mac_clear_acc = mac_clr_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_idx       = out_idx_q;

endmodule
